// File: rtl/ff_force_arbiter_if.sv
// ff_force_arbiter_if: requester/bank bus for ff_force_arbiter.
// master = requesters and bank source; slave = the arbiter itself.
`default_nettype none

interface ff_force_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 8,
   parameter int HOLD_W = 4
);
   logic [WIDTH-1:0]       d;
   logic                   d_en;
   logic [NREQ-1:0]        req;
   logic [NREQ*WIDTH-1:0]  req_val;
   logic [NREQ*HOLD_W-1:0] req_hold;
   logic [WIDTH-1:0]       q;
   logic [NREQ-1:0]        gnt;
   logic                   ovr_active;
   logic                   busy;
   logic                   done;

   modport master (
      output d, d_en, req, req_val, req_hold,
      input  q, gnt, ovr_active, busy, done
   );

   modport slave (
      input  d, d_en, req, req_val, req_hold,
      output q, gnt, ovr_active, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/ff_force_arbiter.sv
// ff_force_arbiter: register bank with round-robin, time-limited value override.
// Optional FRC_WRITEBACK_EN: the forced value is written into the bank on release.
`default_nettype none

module ff_force_arbiter #(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 8,
   parameter int HOLD_W = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   ff_force_arbiter_if.slave     bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_FORCE   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  r_frc;
   logic [HOLD_W-1:0] r_cnt;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  r_gidx;
   logic [NREQ-1:0]   r_gnt;
   logic              r_ovr;
   logic              r_busy;
   logic              r_done;

   logic              w_found;
   logic [PTR_W-1:0]  w_pick;
   logic [PTR_W:0]    w_sum;
   logic [HOLD_W-1:0] w_hold;
   logic [WIDTH-1:0]  w_val;
   logic [PTR_W-1:0]  w_next_ptr;

   // Scan requesters starting at the pointer, wrapping past NREQ-1.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
         if (w_sum >= (PTR_W+1)'(NREQ))
            w_sum = w_sum - (PTR_W+1)'(NREQ);
         if (!w_found && bus.req[w_sum[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_sum[PTR_W-1:0];
         end
      end
   end

   assign w_hold     = bus.req_hold[r_gidx*HOLD_W +: HOLD_W];
   assign w_val      = bus.req_val[r_gidx*WIDTH +: WIDTH];
   assign w_next_ptr = (r_gidx == PTR_W'(NREQ-1)) ? '0 : r_gidx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_q     <= '0;
         r_frc   <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_gnt   <= '0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.d_en)
            r_q <= bus.d;

         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt   <= NREQ'(1) << w_pick;
                  r_gidx  <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // A zero hold still yields one forced cycle.
               r_frc   <= w_val;
               r_cnt   <= (w_hold == '0) ? HOLD_W'(1) : w_hold;
               r_ovr   <= 1'b1;
               r_state <= ST_FORCE;
            end
            ST_FORCE: begin
               if ((r_cnt <= HOLD_W'(1)) || !bus.req[r_gidx]) begin
                  r_ovr   <= 1'b0;
                  r_done  <= 1'b1;
                  r_gnt   <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_RELEASE;
`ifdef FRC_WRITEBACK_EN
                  // Written on the same edge the override drops so q never glitches.
                  r_q     <= r_frc;
`endif
               end else begin
                  r_cnt <= r_cnt - HOLD_W'(1);
               end
            end
            ST_RELEASE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.q          = r_ovr ? r_frc : r_q;
   assign bus.gnt        = r_gnt;
   assign bus.ovr_active = r_ovr;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
endmodule

`default_nettype wire

// File: tb/tb_ff_force_arbiter.sv
// tb_ff_force_arbiter: scenario tasks with queued expectations for ff_force_arbiter.
`default_nettype none

module tb_ff_force_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   ff_force_arbiter_if #(.NREQ(4), .WIDTH(8), .HOLD_W(4)) bus ();

   ff_force_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] q_exp[$];
   logic       d_exp[$];
   logic [3:0] g_exp[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_field(input int i, input logic [7:0] v, input logic [3:0] h);
      bus.req_val[i*8 +: 8]  = v;
      bus.req_hold[i*4 +: 4] = h;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      bus.d = 8'h00; bus.d_en = 1'b0; bus.req = '0;
      bus.req_val = '0; bus.req_hold = '0;
      rst = 1'b0;
      tick();
      n_checks++;
      if ({bus.q, bus.gnt, bus.ovr_active, bus.busy, bus.done} !== 15'h0) begin
         $display("FAIL reset_state: got q=%h gnt=%b ovr=%b busy=%b done=%b, need all 0",
                  bus.q, bus.gnt, bus.ovr_active, bus.busy, bus.done);
         n_errors++;
      end
      tick();
      rst = 1'b1;
      bus.d = 8'h3C; bus.d_en = 1'b1;
      tick();
      n_checks++;
      if (bus.q !== 8'h3C) begin
         $display("FAIL reset_load: got q=%h need 3c", bus.q);
         n_errors++;
      end
      n_checks++;
      if ({bus.gnt, bus.busy, bus.done} !== 6'h0) begin
         $display("FAIL reset_idle: got gnt=%b busy=%b done=%b need 0", bus.gnt, bus.busy, bus.done);
         n_errors++;
      end
   endtask

   task automatic test_force();
      logic [7:0] eq;
      logic       ed;
      int         ndone;
      bus.d = 8'h11;
      set_field(1, 8'hA5, 4'd3);
      bus.req = 4'b0010;
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1 || bus.q !== 8'h11) begin
         $display("FAIL force_grant: got gnt=%b busy=%b q=%h need 0010 1 11", bus.gnt, bus.busy, bus.q);
         n_errors++;
      end
      q_exp.push_back(8'hA5); d_exp.push_back(1'b0);
      q_exp.push_back(8'hA5); d_exp.push_back(1'b0);
      q_exp.push_back(8'hA5); d_exp.push_back(1'b0);
      q_exp.push_back(8'h11); d_exp.push_back(1'b1);
      q_exp.push_back(8'h11); d_exp.push_back(1'b0);
      ndone = 0;
      while (q_exp.size() > 0) begin
         tick();
         eq = q_exp.pop_front();
         ed = d_exp.pop_front();
         if (bus.done) ndone++;
         if (ed) bus.req = '0;
         n_checks++;
         if (bus.q !== eq || bus.done !== ed) begin
            $display("FAIL force_seq: got q=%h done=%b need q=%h done=%b", bus.q, bus.done, eq, ed);
            n_errors++;
         end
      end
      n_checks++;
      if (ndone != 1 || bus.busy !== 1'b0) begin
         $display("FAIL force_done_once: got %0d pulses busy=%b need 1 pulse busy=0", ndone, bus.busy);
         n_errors++;
      end
   endtask

   task automatic test_round_robin();
      int         cyc, last, dones;
      logic [3:0] prev, eg;
      pulse_reset();
      bus.d = 8'h11; bus.d_en = 1'b1;
      set_field(0, 8'h10, 4'd1); set_field(1, 8'h21, 4'd1);
      set_field(2, 8'h32, 4'd1); set_field(3, 8'h43, 4'd1);
      g_exp.push_back(4'b0001); g_exp.push_back(4'b0010);
      g_exp.push_back(4'b1000); g_exp.push_back(4'b0001);
      bus.req = 4'b1011;
      cyc = 0; last = -1; dones = 0; prev = '0;
      while (g_exp.size() > 0 && cyc < 40) begin
         tick();
         cyc++;
         if (bus.done) dones++;
         if (bus.gnt != 4'b0000 && prev == 4'b0000) begin
            eg = g_exp.pop_front();
            n_checks++;
            if (bus.gnt !== eg) begin
               $display("FAIL rr_order: got gnt=%b need %b", bus.gnt, eg);
               n_errors++;
            end
            if (last >= 0) begin
               n_checks++;
               if (cyc - last != 4 || dones != 1) begin
                  $display("FAIL rr_spacing: got %0d cycles %0d dones need 4 cycles 1 done", cyc - last, dones);
                  n_errors++;
               end
            end
            last = cyc; dones = 0;
         end
         prev = bus.gnt;
      end
      n_checks++;
      if (g_exp.size() != 0) begin
         $display("FAIL rr_timeout: got %0d grants outstanding need 0", g_exp.size());
         n_errors++;
         g_exp.delete();
      end
      bus.req = '0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 20) begin tick(); cyc++; end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.ovr_active !== 1'b0) begin
         $display("FAIL rr_idle: got busy=%b gnt=%b ovr=%b need 0", bus.busy, bus.gnt, bus.ovr_active);
         n_errors++;
      end
   endtask

   task automatic test_abort();
      logic [7:0] eq;
      set_field(2, 8'h5A, 4'd15);
      bus.req = 4'b0100;
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0100) begin
         $display("FAIL abort_grant: got gnt=%b need 0100", bus.gnt);
         n_errors++;
      end
      q_exp.push_back(8'h5A); q_exp.push_back(8'h5A); q_exp.push_back(8'h11);
      for (int k = 0; k < 3; k++) begin
         tick();
         eq = q_exp.pop_front();
         if (k == 1) bus.req = '0;
         n_checks++;
         if (bus.q !== eq) begin
            $display("FAIL abort_q: cycle %0d got q=%h need %h", k, bus.q, eq);
            n_errors++;
         end
      end
      n_checks++;
      if (bus.done !== 1'b1 || bus.ovr_active !== 1'b0) begin
         $display("FAIL abort_release: got done=%b ovr=%b need 1 0", bus.done, bus.ovr_active);
         n_errors++;
      end
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         $display("FAIL abort_idle: got busy=%b done=%b need 0 0", bus.busy, bus.done);
         n_errors++;
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      set_field(1, 8'h77, 4'd15);
      set_field(3, 8'h88, 4'd15);
      bus.req = 4'b1010;
      tick();
      n_checks++;
      if (bus.gnt !== 4'b1000) begin
         $display("FAIL areset_pre_grant: got gnt=%b need 1000", bus.gnt);
         n_errors++;
      end
      tick();
      n_checks++;
      if (bus.q !== 8'h88 || bus.ovr_active !== 1'b1) begin
         $display("FAIL areset_forced: got q=%h ovr=%b need 88 1", bus.q, bus.ovr_active);
         n_errors++;
      end
      rst = 1'b0;
      #2;
      n_checks++;
      if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.ovr_active !== 1'b0 || bus.busy !== 1'b0) begin
         $display("FAIL areset_async: got q=%h gnt=%b ovr=%b busy=%b need 0", bus.q, bus.gnt, bus.ovr_active, bus.busy);
         n_errors++;
      end
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0010) begin
         $display("FAIL areset_ptr0: got gnt=%b need 0010", bus.gnt);
         n_errors++;
      end
      bus.req = '0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 20) begin tick(); cyc++; end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         $display("FAIL areset_drain: got busy=%b need 0", bus.busy);
         n_errors++;
      end
   endtask

   task automatic test_hold_zero();
      logic [7:0] post, eq;
`ifdef FRC_WRITEBACK_EN
      post = 8'hFF;
`else
      post = 8'h42;
`endif
      bus.d = 8'h42; bus.d_en = 1'b1;
      tick();
      bus.d = 8'h99; bus.d_en = 1'b0;
      set_field(0, 8'hFF, 4'd0);
      bus.req = 4'b0001;
      tick();
      n_checks++;
      if (bus.gnt !== 4'b0001 || bus.q !== 8'h42) begin
         $display("FAIL hold0_grant: got gnt=%b q=%h need 0001 42", bus.gnt, bus.q);
         n_errors++;
      end
      q_exp.push_back(8'hFF); q_exp.push_back(post); q_exp.push_back(post);
      for (int k = 0; k < 3; k++) begin
         tick();
         eq = q_exp.pop_front();
         if (k == 0) bus.req = '0;
         n_checks++;
         if (bus.q !== eq) begin
            $display("FAIL hold0_q: cycle %0d got q=%h need %h", k, bus.q, eq);
            n_errors++;
         end
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.ovr_active !== 1'b0) begin
         $display("FAIL hold0_idle: got busy=%b ovr=%b need 0 0", bus.busy, bus.ovr_active);
         n_errors++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_force();
      test_round_robin();
      test_abort();
      test_async_reset();
      test_hold_zero();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout need completion");
      $fatal(1, "watchdog expired");
   end
endmodule

`default_nettype wire

// File: doc/ff_force_arbiter.md
Name: ff_force_arbiter

Overview:
Owns a WIDTH-bit D-flip-flop register bank and arbitrates override ("force") requests from NREQ requesters. Each requester can force the bank output to a value for a programmed number of cycles, after which the override is released.
- Grants are round-robin, one override at a time.
- Sits between the requesters and the register bank it sequences; replaces ad-hoc procedural force/release with synthesizable control.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, register bank width
HOLD_W, 4, width of per-requester hold-count field

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
d  input  WIDTH  bank data in
d_en  input  1  bank load enable
req  input  NREQ  override request, one bit per requester, level-held
req_val  input  NREQ*WIDTH  forced value, requester i at bits [i*WIDTH +: WIDTH]
req_hold  input  NREQ*HOLD_W  hold cycles, requester i at bits [i*HOLD_W +: HOLD_W]
q  output  WIDTH  bank output (forced value or stored value)
gnt  output  NREQ  one-hot grant, registered
ovr_active  output  1  q currently driven by the forced value
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse on release

Behaviour:
- Reset (rst low, asynchronous): all of the following clear to 0: q_reg, gnt, ovr_active, busy, done, frc_val, hold counter. RR pointer resets to 0 and the FSM enters IDLE.
- Register bank: on a clk rising edge with d_en=1, q_reg <= d. The bank keeps tracking d during an override.
- Output: q = ovr_active ? frc_val : q_reg (combinational mux).
- FSM has four states:
  - IDLE: if any req bit is set, pick the first set bit at or after the RR pointer (wrapping), set gnt one-hot, go to LOAD. busy=0 only in IDLE.
  - LOAD (1 cycle): latch frc_val and cnt from the granted fields. hold=0 is treated as 1. Set ovr_active=1, go to FORCE.
  - FORCE: ovr_active=1. Decrement cnt each cycle. When cnt reaches 1, or the granted req drops, go to RELEASE next edge. A dropped req aborts the override early.
  - RELEASE (1 cycle): ovr_active=0, done=1, gnt cleared. RR pointer <= granted index + 1 mod NREQ. Go to IDLE.
- Latency:
  - IDLE with req seen → gnt visible after 1 edge.
  - q shows the forced value 2 edges after req.
  - q is forced for exactly hold cycles (minimum 1), counted from the first FORCE cycle.
- Minimum request-to-request spacing is 4 cycles, because IDLE is always revisited.
- New requests arriving during LOAD, FORCE or RELEASE are queued by level only; no request is lost while it is held.
- If the requester changes req_val or req_hold after LOAD, the change has no effect on the current override.
- An async reset mid-override drops the force immediately: q = q_reg = 0.
- NREQ=1 degenerates to a plain pointer-fixed grant.

Optional Feature:
FRC_WRITEBACK_EN
- Defined: in the RELEASE cycle, q_reg <= frc_val regardless of d_en or d. The forced value persists after release until the next d_en load.
- Undefined: q_reg follows only d/d_en. After release, q immediately shows whatever q_reg tracked during the override.

Test Plan:
1. rst low, then high; d=8'h3C, d_en=1 → q=8'h3C next cycle. gnt=0, busy=0, done=0 throughout.
2. req=4'b0010, req_val[1]=8'hA5, hold[1]=3, d held at 8'h11 → gnt=4'b0010 after 1 edge, q=8'hA5 for exactly 3 cycles, done pulses once, then q=8'h11.
3. req=4'b1011 held continuously, all holds=1, pointer=0 → grant order 0,1,3,0 at 4-cycle spacing, with done between each grant.
4. req[2] asserted with hold=15, deasserted after 2 FORCE cycles → RELEASE on the next edge, and q returns to q_reg early.
5. rst pulsed low during FORCE → q, gnt and ovr_active go to 0 asynchronously; after release of rst, the first grant goes to the lowest set req (pointer 0).
6. hold=0 with value 8'hFF → exactly 1 forced cycle. With FRC_WRITEBACK_EN and d_en=0 → q stays 8'hFF after release; without it → q reverts to the prior q_reg.
